// File: rtl/fp16_mul_pkg.sv
// Shared types for the FP16 multiplier scheduler.
// Operand and result buses are plain 16-bit half-precision words.
package fp16_mul_pkg;
    localparam int FP16_W = 16;
    typedef logic [FP16_W-1:0] fp16_t;
endpackage

// File: rtl/fp16_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request strictly after ptr, wrapping around.
// Latency: combinational. Backpressure: en=0 forces an all-zero grant.
// Grant depends on req only; requesters must not build req from the grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);
    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NREQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp16_mul_scheduler.sv
// Shares one fixed-latency FP16 multiplier among NREQ requesters with round-robin issue.
// Latency: handshake cycle t -> mul_active t+1 -> rsp_valid t+MUL_LAT+2.
// Backpressure: mul_stall blocks new grants only; responses cannot be stalled.
module fp16_mul_scheduler
    import fp16_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FP16_W-1:0]   req_fp1,
    input  logic [NREQ*FP16_W-1:0]   req_fp2,
    input  logic                     mul_stall,
    output logic                     mul_active,
    output fp16_t                    mul_fp1,
    output fp16_t                    mul_fp2,
    input  fp16_t                    mul_result,
    output logic [NREQ-1:0]          rsp_valid,
    output fp16_t                    rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ID_W+2:0]          inflight,
    output logic                     idle
);
    localparam int CNT_W = ID_W + 3;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } mul_tag_t;

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             hs;
    fp16_t            fp1_lane [NREQ];
    fp16_t            fp2_lane [NREQ];

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             mul_active_q, mul_active_d;
    fp16_t            mul_fp1_q, mul_fp1_d, mul_fp2_q, mul_fp2_d;
    // Stage 0 rides alongside the operand register; the remaining MUL_LAT
    // stages track the multiplier's own pipeline.
    mul_tag_t         tag_q [MUL_LAT+1];
    mul_tag_t         tag_d [MUL_LAT+1];
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    fp16_t            rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .en     (~mul_stall & nRST),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            fp1_lane[i] = req_fp1[i*FP16_W +: FP16_W];
            fp2_lane[i] = req_fp2[i*FP16_W +: FP16_W];
        end
        hs           = |gnt;
        ptr_d        = hs ? gnt_id : ptr_q;
        mul_active_d = hs;
        mul_fp1_d    = hs ? fp1_lane[gnt_id] : mul_fp1_q;
        mul_fp2_d    = hs ? fp2_lane[gnt_id] : mul_fp2_q;
        tag_d[0]     = '{v: hs, id: gnt_id};
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        if (tag_q[MUL_LAT].v) begin
            rsp_valid_d = NREQ'(1) << tag_q[MUL_LAT].id;
            rsp_data_d  = mul_result;
            rsp_id_d    = tag_q[MUL_LAT].id;
        end
        // An op leaves the count in the cycle its response is presented.
        inflight_d = inflight_q + CNT_W'(hs) - CNT_W'(|rsp_valid_q);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q        <= ID_W'(NREQ - 1);
            mul_active_q <= 1'b0;
            mul_fp1_q    <= '0;
            mul_fp2_q    <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            inflight_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            mul_active_q <= mul_active_d;
            mul_fp1_q    <= mul_fp1_d;
            mul_fp2_q    <= mul_fp2_d;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            inflight_q   <= inflight_d;
        end
    end

    assign req_ready  = gnt;
    assign mul_active = mul_active_q;
    assign mul_fp1    = mul_fp1_q;
    assign mul_fp2    = mul_fp2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign inflight   = inflight_q;
    assign idle       = (inflight_q == '0) && (req_valid == '0);
endmodule

// File: tb/tb_fp16_mul_scheduler.sv
// Bench for fp16_mul_scheduler: directed issue patterns, scoreboarded responses,
// behavioural 3-stage FP16 multiplier (normal numbers, truncating).
module tb_fp16_mul_scheduler;
    localparam int NREQ = 4;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        nRST;
    logic [3:0]  req_valid, req_ready, rsp_valid;
    logic [63:0] req_fp1, req_fp2;
    logic        mul_stall, mul_active, idle;
    logic [15:0] mul_fp1, mul_fp2, mul_result, rsp_data;
    logic [1:0]  rsp_id;
    logic [4:0]  inflight;

    fp16_mul_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
        .req_fp1(req_fp1), .req_fp2(req_fp2), .mul_stall(mul_stall),
        .mul_active(mul_active), .mul_fp1(mul_fp1), .mul_fp2(mul_fp2),
        .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [6:0]  e;
        logic [9:0]  m;
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = 7'(a[14:10]) + 7'(b[14:10]) - 7'd15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 7'd1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    logic [15:0] mstage [MUL_LAT];
    always @(posedge clk) begin
        mstage[0] <= fp16_mul(mul_fp1, mul_fp2);
        for (int k = 1; k < MUL_LAT; k++) mstage[k] <= mstage[k-1];
    end
    assign mul_result = mstage[MUL_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t        sb_q [$];
    int          gnt_log [$];
    logic [15:0] exp_prod [NREQ];
    int          inflight_m = 0;
    int          peak = 0;
    logic        prev_hs = 1'b0;
    logic [15:0] prev_a, prev_b;

    // Monitor: responses against scoreboard, issue-side registers against the previous handshake.
    always @(negedge clk) begin
        if (!nRST) begin
            sb_q.delete();
            inflight_m = 0;
            prev_hs = 1'b0;
        end else begin
            logic hs_now;
            int   hid;
            exp_t e;
            if (rsp_valid != 4'b0) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_valid_onehot", rsp_valid, 4'b1 << e.id);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_latency", cyc, e.due);
                end
            end
            chk("mul_active", mul_active, prev_hs);
            if (prev_hs) begin
                chk("mul_fp1", mul_fp1, prev_a);
                chk("mul_fp2", mul_fp2, prev_b);
            end
            chk("grant_onehot", ($countones(req_ready) <= 1), 1);
            chk("grant_needs_valid", req_ready & ~req_valid, 0);
            if (mul_stall) chk("stall_blocks_grant", req_ready, 0);
            chk("inflight", inflight, inflight_m);
            chk("idle", idle, (inflight_m == 0) && (req_valid == 4'b0));
            if (int'(inflight) > peak) peak = int'(inflight);

            hs_now = 1'b0;
            hid = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_now = 1'b1;
                    hid = i;
                end
            end
            if (hs_now) begin
                sb_q.push_back('{id: hid, data: exp_prod[hid], due: cyc + MUL_LAT + 2});
                gnt_log.push_back(hid);
                prev_a = req_fp1[16*hid +: 16];
                prev_b = req_fp2[16*hid +: 16];
            end
            prev_hs = hs_now;
            inflight_m = inflight_m + (hs_now ? 1 : 0) - ((rsp_valid != 4'b0) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] p);
        req_fp1[16*i +: 16] = a;
        req_fp2[16*i +: 16] = b;
        exp_prod[i] = p;
    endtask

    task automatic drain();
        int budget = 30;
        while (sb_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("drain_outstanding", sb_q.size(), 0);
        tick(2);
    endtask

    task automatic check_grants(input string name, input int exp_g [$]);
        chk({name, "_count"}, gnt_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < gnt_log.size(); i++)
            chk({name, "_order"}, gnt_log[i], exp_g[i]);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mul_active", mul_active, 0);
        chk("rst_mul_fp1", mul_fp1, 0);
        chk("rst_mul_fp2", mul_fp2, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_inflight", inflight, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        req_valid = '0;
        req_fp1 = '0;
        req_fp2 = '0;
        mul_stall = 1'b0;
        for (int i = 0; i < NREQ; i++) exp_prod[i] = '0;
        check_reset_outputs();
        tick(1);
        nRST = 1'b1;
        tick(2);

        // All four requesters continuously: strict rotation starting at 0.
        set_req(0, 16'h3C00, 16'h4000, 16'h4000);
        set_req(1, 16'h3E00, 16'h4000, 16'h4200);
        set_req(2, 16'h4000, 16'h4200, 16'h4600);
        set_req(3, 16'h3800, 16'h3800, 16'h3400);
        gnt_log.delete();
        req_valid = 4'hF;
        tick(8);
        req_valid = 4'h0;
        check_grants("rr_all4", '{0, 1, 2, 3, 0, 1, 2, 3});
        drain();

        // Single op: 1.0 * 2.0 from requester 0.
        gnt_log.delete();
        req_valid = 4'b0001;
        tick(1);
        req_valid = 4'h0;
        check_grants("single_req0", '{0});
        drain();

        // Requesters 1 and 3 with a three-cycle stall window.
        set_req(1, 16'hBC00, 16'h4000, 16'hC000);
        set_req(3, 16'h4400, 16'h3C00, 16'h4400);
        gnt_log.delete();
        req_valid = 4'b1010;
        tick(2);
        mul_stall = 1'b1;
        tick(3);
        mul_stall = 1'b0;
        tick(3);
        req_valid = 4'h0;
        check_grants("stall_rr", '{1, 3, 1, 3, 1});
        drain();

        // Lone requester 2 granted every cycle; occupancy peaks at MUL_LAT+2.
        set_req(2, 16'h4200, 16'h4200, 16'h4880);
        gnt_log.delete();
        peak = 0;
        req_valid = 4'b0100;
        tick(6);
        req_valid = 4'h0;
        check_grants("lone_req2", '{2, 2, 2, 2, 2, 2});
        drain();
        @(negedge clk);
        chk("peak_inflight", peak, 5);
        chk("final_inflight", inflight, 0);
        chk("final_idle", idle, 1);
        tick(1);

        // Random normal operands on random requester subsets.
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                logic [15:0] a, b;
                a = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
                b = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
                set_req(i, a, b, fp16_mul(a, b));
            end
            tick(1);
        end
        req_valid = 4'h0;
        drain();

        // Reset with three ops in flight: everything discarded.
        set_req(0, 16'h3C00, 16'h4000, 16'h4000);
        set_req(1, 16'h3E00, 16'h4000, 16'h4200);
        set_req(2, 16'h4000, 16'h4200, 16'h4600);
        req_valid = 4'b0111;
        tick(3);
        req_valid = 4'h0;
        nRST = 1'b0;
        check_reset_outputs();
        tick(1);
        nRST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_reset_quiet", rsp_valid, 0);
        end
        chk("post_reset_inflight", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
